// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline stage: FSM states, control and payload bundles,
// and the branch-resolution helper.
package ex_mem_pkg;

  localparam int unsigned LENGTH   = 32;
  localparam int unsigned REG_ADDR = 5;

  // Occupancy of the two-entry elastic buffer.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  typedef struct packed {
    logic [LENGTH-1:0]   alu_result;
    logic [LENGTH-1:0]   store_data;
    logic [REG_ADDR-1:0] rd;
    ctrl_t               ctrl;
  } payload_t;

  // beq is taken on zero, bne on non-zero.
  function automatic logic branch_taken(input logic branch, input logic zero, input logic ne);
    return branch & (zero ^ ne);
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One loadable payload register of the EX/MEM elastic buffer; clears on async reset and
// otherwise holds its contents until the next load.
module ex_mem_slot
  import ex_mem_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     load_i,
  input  payload_t d_i,
  output payload_t q_o
);

  payload_t data_q;

  // Capture the incoming bundle on load, hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry elastic buffer (head + skid) between execute and data
// memory, with branch resolution at accept. o_ready is decoded from registered state only.
// Optional forwarding outputs from the head entry are enabled by defining EX_MEM_FWD_EN.
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [LENGTH-1:0]   i_alu_result,
  input  logic                i_alu_zero,
  input  logic [LENGTH-1:0]   i_store_data,
  input  logic [REG_ADDR-1:0] i_rd,
  input  logic                i_reg_write,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic                i_branch,
  input  logic                i_branch_ne,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [LENGTH-1:0]   o_alu_result,
  output logic [LENGTH-1:0]   o_store_data,
  output logic [REG_ADDR-1:0] o_rd,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
`ifdef EX_MEM_FWD_EN
  output logic                o_fwd_valid,
  output logic [REG_ADDR-1:0] o_fwd_rd,
  output logic [LENGTH-1:0]   o_fwd_data,
`else
  // forwarding ports absent
`endif
  output logic                o_branch_taken
);

  state_e   state_q, state_d;
  payload_t in_pl, head_d, head_q, skid_q;
  logic     head_load, skid_load, head_from_skid;
  logic     accept, emit;
  logic     branch_q;

  assign in_pl.alu_result     = i_alu_result;
  assign in_pl.store_data     = i_store_data;
  assign in_pl.rd             = i_rd;
  assign in_pl.ctrl.reg_write = i_reg_write;
  assign in_pl.ctrl.mem_read  = i_mem_read;
  assign in_pl.ctrl.mem_write = i_mem_write;

  assign o_ready = (state_q != StTwo);
  assign o_valid = (state_q != StEmpty);
  assign accept  = i_valid & o_ready;
  assign emit    = o_valid & i_ready;

  // Occupancy transitions and slot load enables; flush overrides accept and emit.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    if (i_flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_load = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (accept && emit) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = StTwo;
          end else if (emit) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (emit) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            state_d        = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  assign head_d = head_from_skid ? skid_q : in_pl;

  // State register; reset drops all held entries immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // One-cycle taken pulse for a branch accepted this cycle, suppressed by flush.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      branch_q <= 1'b0;
    end else begin
      branch_q <= ~i_flush & accept & branch_taken(i_branch, i_alu_zero, i_branch_ne);
    end
  end

  ex_mem_slot u_head (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .load_i (head_load),
    .d_i    (head_d),
    .q_o    (head_q)
  );

  ex_mem_slot u_skid (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .load_i (skid_load),
    .d_i    (in_pl),
    .q_o    (skid_q)
  );

  assign o_alu_result   = head_q.alu_result;
  assign o_store_data   = head_q.store_data;
  assign o_rd           = head_q.rd;
  assign o_reg_write    = o_valid & head_q.ctrl.reg_write;
  assign o_mem_read     = o_valid & head_q.ctrl.mem_read;
  assign o_mem_write    = o_valid & head_q.ctrl.mem_write;
  assign o_branch_taken = branch_q;

`ifdef EX_MEM_FWD_EN
  assign o_fwd_valid = o_reg_write & (o_rd != '0);
  assign o_fwd_rd    = o_rd;
  assign o_fwd_data  = o_alu_result;
`else
  // no forwarding logic
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a driver pushes accepted bundles into an expected
// queue (a plain 2-deep FIFO model); a negedge monitor compares the DUT against it.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        zero;
    logic        br;
    logic        ne;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_alu_zero = 1'b0, i_reg_write = 1'b0, i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0, i_branch = 1'b0, i_branch_ne = 1'b0, i_flush = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_alu_result = '0, i_store_data = '0;
  logic [4:0]  i_rd = '0;
  logic        o_ready, o_valid, o_reg_write, o_mem_read, o_mem_write, o_branch_taken;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0]  o_rd;
`ifdef EX_MEM_FWD_EN
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd;
  logic [31:0] o_fwd_data;
`endif

  bundle_t exp_q[$];
  logic    exp_br = 1'b0;
  int      total = 0;
  int      bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_alu_result   (i_alu_result),
    .i_alu_zero     (i_alu_zero),
    .i_store_data   (i_store_data),
    .i_rd           (i_rd),
    .i_reg_write    (i_reg_write),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_branch       (i_branch),
    .i_branch_ne    (i_branch_ne),
    .i_flush        (i_flush),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_alu_result   (o_alu_result),
    .o_store_data   (o_store_data),
    .o_rd           (o_rd),
    .o_reg_write    (o_reg_write),
    .o_mem_read     (o_mem_read),
    .o_mem_write    (o_mem_write),
`ifdef EX_MEM_FWD_EN
    .o_fwd_valid    (o_fwd_valid),
    .o_fwd_rd       (o_fwd_rd),
    .o_fwd_data     (o_fwd_data),
`endif
    .o_branch_taken (o_branch_taken)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                                 input logic br, input logic ne, input logic zero);
    bundle_t b;
    b      = '0;
    b.alu  = alu;
    b.sd   = alu ^ 32'h5a5a_0f0f;
    b.rd   = rd;
    b.rw   = rw;
    b.br   = br;
    b.ne   = ne;
    b.zero = zero;
    return b;
  endfunction

  function automatic bundle_t rand_b();
    bundle_t b;
    b.alu  = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
    b.sd   = $urandom;
    b.rd   = 5'($urandom_range(31));
    b.rw   = 1'($urandom_range(1));
    b.mr   = 1'($urandom_range(1));
    b.mw   = 1'($urandom_range(1));
    b.zero = 1'($urandom_range(1));
    b.br   = 1'($urandom_range(1));
    b.ne   = 1'($urandom_range(1));
    return b;
  endfunction

  // Present one cycle of stimulus, then update the model with what the edge did.
  task automatic drive(input bundle_t b, input logic v, input logic fl, input logic rdy,
                       output logic acc);
    int held;
    held         = exp_q.size();
    i_valid      = v;
    i_alu_result = b.alu;
    i_store_data = b.sd;
    i_rd         = b.rd;
    i_reg_write  = b.rw;
    i_mem_read   = b.mr;
    i_mem_write  = b.mw;
    i_alu_zero   = b.zero;
    i_branch     = b.br;
    i_branch_ne  = b.ne;
    i_flush      = fl;
    i_ready      = rdy;
    acc          = v && !fl && (held < 2);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      exp_br = 1'b0;
    end else begin
      exp_br = acc && b.br && (b.ne ? !b.zero : b.zero);
      if (acc) exp_q.push_back(b);
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, rdy, acc);
  endtask

  // Keep offering a bundle until the model says it was taken.
  task automatic send(input bundle_t b, input logic rdy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) drive(b, 1'b1, 1'b0, rdy, acc);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  // Monitor: compare outputs with the model head; retire the head on a handshake.
  always @(negedge clk) begin : mon
    int n;
    n = exp_q.size();
    check("o_valid", o_valid, n != 0);
    check("o_ready", o_ready, n < 2);
    check("o_branch_taken", o_branch_taken, exp_br);
    if (n != 0) begin
      check("o_alu_result", o_alu_result, exp_q[0].alu);
      check("o_store_data", o_store_data, exp_q[0].sd);
      check("o_rd", o_rd, exp_q[0].rd);
      check("o_ctrl", {o_reg_write, o_mem_read, o_mem_write},
            {exp_q[0].rw, exp_q[0].mr, exp_q[0].mw});
    end else begin
      check("o_ctrl_idle", {o_reg_write, o_mem_read, o_mem_write}, 3'b000);
    end
`ifdef EX_MEM_FWD_EN
    check("o_fwd_valid", o_fwd_valid, (n != 0) && exp_q[0].rw && (exp_q[0].rd != 5'd0));
    if (n != 0) begin
      check("o_fwd_rd", o_fwd_rd, exp_q[0].rd);
      check("o_fwd_data", o_fwd_data, exp_q[0].alu);
    end
`endif
    if (n != 0 && i_ready && !i_flush && !rst) void'(exp_q.pop_front());
  end

  initial begin
    logic    acc;
    bundle_t b;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_result", o_alu_result, 32'h0);
    check("rst_store_data", o_store_data, 32'h0);
    check("rst_rd", o_rd, 5'd0);
    rst = 1'b0;

    // Single bundle straight through.
    drive(mk(32'h0000_0010, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1, 2);

    // Stall: A to head, B to skid, C held upstream, then drain in order.
    drive(mk(32'haaaa_0001, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    drive(mk(32'hbbbb_0002, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    drive(mk(32'hcccc_0003, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    send(mk(32'hcccc_0003, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    idle(1'b1, 3);

    // Branch resolution: beq with zero is taken, bne with zero is not.
    drive(mk(32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0, acc);
    idle(1'b1, 2);
    drive(mk(32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1, 2);

    // Flush from the full state; the flushed input must never appear.
    drive(mk(32'h1111_0001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    drive(mk(32'h2222_0002, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    drive(mk(32'hdead_beef, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0, acc);
    idle(1'b1, 2);

    // Asynchronous reset while full.
    drive(mk(32'h3333_0003, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    drive(mk(32'h4444_0004, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_ready", o_ready, 1'b1);
    check("async_rst_alu", o_alu_result, 32'h0);
    exp_q.delete();
    exp_br = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forwarding: rd 0 never forwards, rd 7 does.
    drive(mk(32'h0000_0abc, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    idle(1'b1, 1);
    drive(mk(32'h0000_0def, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, acc);
    idle(1'b1, 2);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      b = rand_b();
      drive(b, 1'($urandom_range(3) != 0), 1'($urandom_range(31) == 0),
            1'($urandom_range(2) != 0), acc);
    end
    idle(1'b1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage directly downstream of the ALU: captures the ALU result, zero flag, store data, destination register and memory/write-back controls from execute, resolves conditional branches, and presents the bundle to the data-memory stage. A two-entry elastic buffer with valid/ready handshakes on both sides absorbs data-memory stalls without a combinational ready path back into execute.

## Interface
- LENGTH, 32, datapath width
- REG_ADDR, 5, register-index width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  execute bundle valid
- o_ready  out  1  stage can accept; registered
- i_alu_result  in  LENGTH  ALU result
- i_alu_zero  in  1  ALU zero flag
- i_store_data  in  LENGTH  rs2 value for stores
- i_rd  in  REG_ADDR  destination register
- i_reg_write, i_mem_read, i_mem_write  in  1 each  controls
- i_branch  in  1  instruction is a conditional branch
- i_branch_ne  in  1  branch sense: 0 = beq, 1 = bne
- i_flush  in  1  squash all held entries
- o_valid  out  1  bundle valid to memory stage
- i_ready  in  1  memory stage accepts
- o_alu_result, o_store_data  out  LENGTH  head-entry payload
- o_rd  out  REG_ADDR  head-entry destination
- o_reg_write, o_mem_read, o_mem_write  out  1 each  head-entry controls, gated by o_valid
- o_branch_taken  out  1  one-cycle pulse, branch resolved taken
- o_fwd_valid, o_fwd_rd, o_fwd_data  out  1/REG_ADDR/LENGTH  forwarding (only with macro)

## Operation
- Accept when i_valid & o_ready; emit when o_valid & i_ready.
- States: EMPTY, ONE (head full), TWO (head + skid full).
- EMPTY: accept -> ONE.
- ONE: accept & emit -> ONE (head reloaded); accept only -> TWO (to skid); emit only -> EMPTY.
- TWO: emit -> ONE (skid moves to head); no accept possible.
- o_ready = 0 only in TWO.
- Taken = i_branch & (i_alu_zero ^ i_branch_ne), evaluated at accept.
- i_flush: next state EMPTY, both entries invalidated; same-cycle input dropped; no branch pulse. Flush beats accept and emit.
- Payload registers hold last value when invalid; control outputs forced 0 when o_valid = 0.
- Reset: state EMPTY; o_valid 0, o_ready 1, o_branch_taken 0, all payload/control outputs 0, forwarding outputs 0.

## Timing
- Accept-to-o_valid latency: 1 cycle (EMPTY or ONE with emit).
- Throughput: one bundle per cycle while i_ready = 1.
- o_branch_taken asserts the cycle after accept, for exactly one cycle, regardless of i_ready.
- o_ready falls the cycle after entering TWO, rises the cycle after leaving TWO.
- No combinational path from i_ready to o_ready.
- Reset mid-stall: all held entries lost immediately, outputs at reset values asynchronously.

## Configuration
- EX_MEM_FWD_EN defined: o_fwd_valid = o_valid & o_reg_write & (o_rd != 0); o_fwd_rd = o_rd; o_fwd_data = o_alu_result; combinational from head entry.
- Not defined: the three forwarding ports are absent; no other change.

## Structure
- Shared package ex_mem_pkg: state enum (EMPTY/ONE/TWO), control-bundle struct (reg_write, mem_read, mem_write), payload struct (alu_result, store_data, rd, controls).
- Sub-module ex_mem_slot: one loadable payload register with async reset, instantiated twice (head, skid).

## Test plan
- Reset, then i_valid with alu_result 0x0000_0010, rd 5, reg_write 1, i_ready 1 -> next cycle o_valid 1, o_alu_result 0x10, o_rd 5; following cycle o_valid 0, o_reg_write 0.
- i_ready 0, three back-to-back bundles A, B, C -> A in head, B in skid, o_ready 0 from cycle 3, C held upstream; i_ready 1 -> A, B, C emerge on consecutive cycles.
- i_branch 1, i_branch_ne 0, i_alu_zero 1 -> o_branch_taken pulse one cycle; i_branch_ne 1 with zero 1 -> no pulse.
- State TWO, i_flush with i_valid 1 -> next cycle o_valid 0, o_ready 1, flushed input never appears.
- i_rst asserted while in TWO -> o_valid 0, o_ready 1 without waiting for a clock edge.
- EX_MEM_FWD_EN: head with rd 0, reg_write 1 -> o_fwd_valid 0; rd 7 -> o_fwd_valid 1, o_fwd_data = o_alu_result.
